cmd_credit_pool: RTL

Parametrised PSL command-credit manager for the AFU-Control command path. It replaces the fixed read/write credit split with one shared pool, loaded from the PSL room value. The pool serves NUM_CHANNELS command buffers, each with a guaranteed per-channel reserve, and arbitrates in fixed-priority or round-robin mode. It sits between the command buffers (restart, WED, write, prefetch-write, read, prefetch-read) and the command arbiter, and takes credit returns from the response decoder.

---
 rtl/cmd_credit_pool_pkg.sv | 26 ++
 rtl/cmd_credit_pool_arbiter.sv | 40 ++++
 rtl/cmd_credit_pool.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cmd_credit_pool_pkg.sv
// Shared definitions for the PSL command-credit pool.
// Contents:
//   PRIORITY_*       command-buffer indices; index 0 is the highest priority
//   NUM_CMD_BUFFERS  default channel count, one per command buffer
//   ARB_FIXED / ARB_ROUND_ROBIN  arbitration mode selectors
//   credit_cnt_t     credit counter type sized for the default pool
package cmd_credit_pool_pkg;

  localparam int PRIORITY_RESTART = 0;
  localparam int PRIORITY_WED     = 1;
  localparam int PRIORITY_WRITE   = 2;
  localparam int PRIORITY_PWRITE  = 3;
  localparam int PRIORITY_READ    = 4;
  localparam int PRIORITY_PREAD   = 5;

  localparam int NUM_CMD_BUFFERS  = PRIORITY_PREAD + 1;

  localparam int ARB_FIXED        = 0;
  localparam int ARB_ROUND_ROBIN  = 1;

  localparam int CREDITS_MAX_DEF  = 64;
  localparam int CREDIT_BITS_DEF  = $clog2(CREDITS_MAX_DEF + 1);

  typedef logic [0:CREDIT_BITS_DEF-1] credit_cnt_t;

endpackage

// File: rtl/cmd_credit_pool_arbiter.sv
// credit_arbiter_rr: combinational one-hot picker.
// Ports:
//   elig_i     per-channel eligible vector
//   ptr_i      round-robin start index (ignored in fixed mode)
//   mode_i     0 = fixed priority (lowest index wins), 1 = round robin
//   win_o      one-hot winner
//   win_idx_o  winner index
//   win_vld_o  a winner exists
module credit_arbiter_rr #(
  parameter int N       = 6,
  parameter int CH_BITS = 3
) (
  input  logic [N-1:0]       elig_i,
  input  logic [CH_BITS-1:0] ptr_i,
  input  logic               mode_i,
  output logic [N-1:0]       win_o,
  output logic [CH_BITS-1:0] win_idx_o,
  output logic               win_vld_o
);

  int cand;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    cand      = 0;
    // Scan N candidates starting at the pointer (or at 0 in fixed mode);
    // the first eligible one wins.
    for (int k = 0; k < N; k++) begin
      cand = mode_i ? ((int'(ptr_i) + k) % N) : k;
      if (!win_vld_o && elig_i[CH_BITS'(cand)]) begin
        win_vld_o              = 1'b1;
        win_idx_o              = CH_BITS'(cand);
        win_o[CH_BITS'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_credit_pool.sv
// cmd_credit_pool: shared command-credit pool for the AFU-Control command path.
// One pool, loaded from the PSL room value, serves NUM_CHANNELS command
// buffers, each with a guaranteed reserve of RESERVE credits.
// Ports:
//   clock, rstn          clock, asynchronous active-low reset
//   credit_init_valid    load pool (accepted only with nothing in flight)
//   credit_init_value    pool size, clamped to CREDITS_MAX
//   req                  per-channel level request for one credit
//   grant                registered one-hot pulse, consumes one credit
//   rsp_valid/channel    one credit returned for the given channel
//   credits_free         free credits
//   outstanding          per-channel in-flight counts, channel 0 low slice
//   err_return           sticky: return with nothing outstanding / bad channel
//   err_init             sticky: init attempted while credits in flight
module cmd_credit_pool
  import cmd_credit_pool_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CMD_BUFFERS,
  parameter int CREDITS_MAX  = CREDITS_MAX_DEF,
  parameter int RESERVE      = 2,
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int CREDIT_BITS  = $clog2(CREDITS_MAX + 1),
  parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                              clock,
  input  logic                              rstn,
  input  logic                              credit_init_valid,
  input  logic [CREDIT_BITS-1:0]            credit_init_value,
  input  logic [NUM_CHANNELS-1:0]           req,
  output logic [NUM_CHANNELS-1:0]           grant,
  input  logic                              rsp_valid,
  input  logic [CH_BITS-1:0]                rsp_channel,
  output logic [CREDIT_BITS-1:0]            credits_free,
  output logic [NUM_CHANNELS*CREDIT_BITS-1:0] outstanding,
  output logic                              err_return,
  output logic                              err_init
);

  if (CREDITS_MAX > 64) begin : g_chk_max
    $error("cmd_credit_pool: CREDITS_MAX must not exceed 64");
  end
  if (NUM_CHANNELS * RESERVE > CREDITS_MAX) begin : g_chk_res
    $error("cmd_credit_pool: NUM_CHANNELS*RESERVE exceeds CREDITS_MAX");
  end

  localparam logic [CREDIT_BITS-1:0] RES_C   = CREDIT_BITS'(RESERVE);
  localparam logic [CREDIT_BITS-1:0] MAX_C   = CREDIT_BITS'(CREDITS_MAX);
  localparam logic [CREDIT_BITS-1:0] ONE_C   = CREDIT_BITS'(1);
  localparam logic [CH_BITS-1:0]     LAST_CH = CH_BITS'(NUM_CHANNELS - 1);
  localparam logic [CH_BITS-1:0]     CH_ONE  = CH_BITS'(1);

  function automatic logic [CREDIT_BITS-1:0] clamp_pool(input logic [CREDIT_BITS-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  logic [CREDIT_BITS-1:0]  free_q, free_d;
  logic [CREDIT_BITS-1:0]  out_q [NUM_CHANNELS];
  logic [CREDIT_BITS-1:0]  out_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] grant_q, grant_d;
  logic [CH_BITS-1:0]      ptr_q, ptr_d;
  logic                    err_ret_q, err_ret_d;
  logic                    err_init_q, err_init_d;

  logic [CREDIT_BITS-1:0]  unmet;
  logic                    shared_avail;
  logic                    any_out;
  logic [NUM_CHANNELS-1:0] elig;
  logic [NUM_CHANNELS-1:0] win;
  logic [CH_BITS-1:0]      win_idx;
  logic                    win_vld;
  logic                    init_accept;
  logic                    do_grant;
  logic                    ret_ok;
  logic                    g_hit;
  logic                    r_hit;

  // Reserve accounting: credits still owed to channels below their reserve
  // are fenced off; only the excess is shared.
  always_comb begin
    unmet   = '0;
    any_out = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (out_q[c] < RES_C) unmet = unmet + (RES_C - out_q[c]);
      if (out_q[c] != '0)   any_out = 1'b1;
    end
    shared_avail = (free_q > unmet);
    // A channel's own grant pulse masks it, so a held request is served
    // at most every other cycle.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      elig[c] = req[c] && (free_q != '0) && !grant_q[c] &&
                ((out_q[c] < RES_C) || shared_avail);
    end
  end

  credit_arbiter_rr #(
    .N       (NUM_CHANNELS),
    .CH_BITS (CH_BITS)
  ) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .mode_i    (ARB_MODE == ARB_ROUND_ROBIN),
    .win_o     (win),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

  always_comb begin
    free_d      = free_q;
    out_d       = out_q;
    grant_d     = '0;
    ptr_d       = ptr_q;
    err_ret_d   = err_ret_q;
    err_init_d  = err_init_q;
    ret_ok      = 1'b0;
    g_hit       = 1'b0;
    r_hit       = 1'b0;

    // Init wins over grant; a rejected init leaves traffic untouched.
    init_accept = credit_init_valid && !any_out;
    if (credit_init_valid && any_out) err_init_d = 1'b1;
    do_grant    = win_vld && !init_accept;

    // Out-of-range channels never match, so they fall through to the error.
    if (rsp_valid) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (rsp_channel == CH_BITS'(c) && out_q[c] != '0) ret_ok = 1'b1;
      end
      if (!ret_ok) err_ret_d = 1'b1;
    end

    if (init_accept) begin
      free_d = clamp_pool(credit_init_value);
    end else if (do_grant && !ret_ok) begin
      free_d = free_q - ONE_C;
    end else if (ret_ok && !do_grant) begin
      free_d = free_q + ONE_C;
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      g_hit = do_grant && win[c];
      r_hit = ret_ok && (rsp_channel == CH_BITS'(c));
      if (g_hit && !r_hit)      out_d[c] = out_q[c] + ONE_C;
      else if (r_hit && !g_hit) out_d[c] = out_q[c] - ONE_C;
    end

    if (do_grant) begin
      grant_d = win;
      if (ARB_MODE == ARB_ROUND_ROBIN) ptr_d = (win_idx == LAST_CH) ? '0 : win_idx + CH_ONE;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      free_q     <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      err_ret_q  <= 1'b0;
      err_init_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) out_q[c] <= '0;
    end else begin
      free_q     <= free_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      err_ret_q  <= err_ret_d;
      err_init_q <= err_init_d;
      for (int c = 0; c < NUM_CHANNELS; c++) out_q[c] <= out_d[c];
    end
  end

  assign grant        = grant_q;
  assign credits_free = free_q;
  assign err_return   = err_ret_q;
  assign err_init     = err_init_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign outstanding[c*CREDIT_BITS +: CREDIT_BITS] = out_q[c];
  end

endmodule
